// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32I control FSM, its ALU decoder and the
// datapath units (sign-extension unit uses immSel_e / immSelFor).
package multicycle_control_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_HALT
  } ctrlState_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
    ALU_OR  = 3'b011, ALU_SLT = 3'b101
  } aluControl_e;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00, RES_MEMDATA = 2'b01, RES_ALURESULT = 2'b10
  } resultSrc_e;

  typedef enum logic [1:0] {
    SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10
  } aluSrcA_e;

  typedef enum logic [1:0] {
    SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10
  } aluSrcB_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11
  } immSel_e;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10
  } aluOp_e;

  // fetchWrite/branch/jump are qualified later by memReady, zero and reset.
  typedef struct packed {
    logic        adrSrc;
    logic        memWrite;
    logic        regWrite;
    logic        fetchWrite;
    logic        branch;
    logic        jump;
    resultSrc_e  resultSrc;
    aluSrcA_e    aluSrcA;
    aluSrcB_e    aluSrcB;
    aluOp_e      aluOp;
  } ctrlWord_t;

  function automatic ctrlWord_t stateControls(input ctrlState_e s);
    ctrlWord_t c;
    c.adrSrc     = 1'b0;
    c.memWrite   = 1'b0;
    c.regWrite   = 1'b0;
    c.fetchWrite = 1'b0;
    c.branch     = 1'b0;
    c.jump       = 1'b0;
    c.resultSrc  = RES_ALUOUT;
    c.aluSrcA    = SRCA_PC;
    c.aluSrcB    = SRCB_RS2;
    c.aluOp      = ALUOP_ADD;
    case (s)
      S_FETCH: begin
        c.aluSrcB    = SRCB_FOUR;
        c.resultSrc  = RES_ALURESULT;
        c.fetchWrite = 1'b1;
      end
      S_DECODE: begin
        c.aluSrcA = SRCA_OLDPC;
        c.aluSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        c.aluSrcA = SRCA_RS1;
        c.aluSrcB = SRCB_IMM;
      end
      S_MEMREAD:  c.adrSrc = 1'b1;
      S_MEMWB: begin
        c.resultSrc = RES_MEMDATA;
        c.regWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adrSrc   = 1'b1;
        c.memWrite = 1'b1;
      end
      S_EXECUTER: begin
        c.aluSrcA = SRCA_RS1;
        c.aluOp   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        c.aluSrcA = SRCA_RS1;
        c.aluSrcB = SRCB_IMM;
        c.aluOp   = ALUOP_FUNCT;
      end
      S_ALUWB:    c.regWrite = 1'b1;
      S_BEQ: begin
        c.aluSrcA = SRCA_RS1;
        c.aluOp   = ALUOP_SUB;
        c.branch  = 1'b1;
      end
      S_JAL: begin
        c.aluSrcA = SRCA_OLDPC;
        c.aluSrcB = SRCB_FOUR;
        c.jump    = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic immSel_e immSelFor(input logic [6:0] opcode);
    case (opcode)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction fields in, datapath controls out; master is the control FSM side.
// o_illegal exists only with MULTICYCLE_CTRL_ILLEGAL_TRAP_EN defined.
interface multicycle_control_if;

  logic [6:0] i_opcode;
  logic [2:0] i_funct3;
  logic       i_funct7b5;
  logic       i_zero;
  logic       i_memReady;

  logic       o_pcWrite;
  logic       o_adrSrc;
  logic       o_memWrite;
  logic       o_irWrite;
  logic       o_regWrite;
  logic [1:0] o_resultSrc;
  logic [1:0] o_aluSrcA;
  logic [1:0] o_aluSrcB;
  logic [2:0] o_aluControl;
  logic [1:0] o_immediateSelect;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic       o_illegal;
`endif

  modport master (
    input  i_opcode, i_funct3, i_funct7b5, i_zero, i_memReady,
    output o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_regWrite,
           o_resultSrc, o_aluSrcA, o_aluSrcB, o_aluControl, o_immediateSelect
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    , output o_illegal
`endif
  );

  modport slave (
    output i_opcode, i_funct3, i_funct7b5, i_zero, i_memReady,
    input  o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_regWrite,
           o_resultSrc, o_aluSrcA, o_aluSrcB, o_aluControl, o_immediateSelect
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    , input o_illegal
`endif
  );

endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Maps the FSM's ALU operation class plus funct fields onto the ALU control code.
module multicycle_control_alu_decoder
  import multicycle_control_pkg::*;
(
  input  aluOp_e      i_aluOp,
  input  logic [2:0]  i_funct3,
  input  logic        i_funct7b5,
  input  logic        i_opcodeB5,
  output aluControl_e o_aluControl
);

  // Opcode bit 5 separates R-type from I-type, so addi never becomes a subtract.
  always_comb begin
    o_aluControl = ALU_ADD;
    case (i_aluOp)
      ALUOP_SUB: o_aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  o_aluControl = (i_opcodeB5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_aluControl = ALU_SLT;
          3'b110:  o_aluControl = ALU_OR;
          3'b111:  o_aluControl = ALU_AND;
          default: o_aluControl = ALU_ADD;
        endcase
      end
      default: o_aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I datapath (lw, sw, R, I-ALU, beq, jal).
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes in a sticky HALT state.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input logic                  i_clk,
  input logic                  i_rst,
  multicycle_control_if.master bus
);

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  localparam ctrlState_e IllegalNext = S_HALT;
`else
  localparam ctrlState_e IllegalNext = S_FETCH;
`endif

  ctrlState_e  state_q, state_d;
  ctrlWord_t   ctrl_q;
  aluControl_e aluControl;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (bus.i_memReady) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.i_opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = IllegalNext;
        endcase
      end
      S_MEMADR:   state_d = (bus.i_opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.i_memReady) state_d = S_MEMWB;
      S_MEMWRITE: if (bus.i_memReady) state_d = S_FETCH;
      S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ:       state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // Controls are registered from the next state so they are glitch-free Moore outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_FETCH;
      ctrl_q  <= stateControls(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= stateControls(state_d);
    end
  end

  multicycle_control_alu_decoder u_aluDecoder (
    .i_aluOp      (ctrl_q.aluOp),
    .i_funct3     (bus.i_funct3),
    .i_funct7b5   (bus.i_funct7b5),
    .i_opcodeB5   (bus.i_opcode[5]),
    .o_aluControl (aluControl)
  );

  // Reset must silence every enable at once, including FETCH's memReady-driven loads.
  assign bus.o_irWrite  = ~i_rst & ctrl_q.fetchWrite & bus.i_memReady;
  assign bus.o_pcWrite  = ~i_rst & ((ctrl_q.fetchWrite & bus.i_memReady)
                                  | (ctrl_q.branch & bus.i_zero)
                                  | ctrl_q.jump);
  assign bus.o_memWrite = ~i_rst & ctrl_q.memWrite;
  assign bus.o_regWrite = ~i_rst & ctrl_q.regWrite;

  assign bus.o_adrSrc          = ctrl_q.adrSrc;
  assign bus.o_resultSrc       = ctrl_q.resultSrc;
  assign bus.o_aluSrcA         = ctrl_q.aluSrcA;
  assign bus.o_aluSrcB         = ctrl_q.aluSrcB;
  assign bus.o_aluControl      = aluControl;
  assign bus.o_immediateSelect = immSelFor(bus.i_opcode);

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  assign bus.o_illegal = (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes per-cycle expectations built
// from each instruction's phase sequence; a negedge monitor pops and compares them.
module tb_multicycle_control;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  typedef enum {PH_RST, PH_F, PH_D, PH_MA, PH_MR, PH_MWB, PH_MW,
                PH_ER, PH_EI, PH_WB, PH_BEQ, PH_JAL, PH_HALT} phase_e;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [16:0] expQ[$];
  phase_e      phQ[$];

  multicycle_control_if bus();

  multicycle_control dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [2:0] functOp(input logic [31:0] ins);
    case (ins[14:12])
      3'b000:  return (ins[6:0] == RT && ins[30]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs for one cycle of a given instruction phase.
  function automatic logic [16:0] expVec(input phase_e ph, input logic [31:0] ins,
                                         input logic rdy, input logic z);
    logic pcW, adr, memW, irW, regW, ill;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu;
    {pcW, adr, memW, irW, regW, ill} = '0;
    {res, sa, sb, imm} = '0;
    alu = 3'b000;
    case (ins[6:0])
      SW:      imm = 2'b01;
      BQ:      imm = 2'b10;
      JL:      imm = 2'b11;
      default: imm = 2'b00;
    endcase
    case (ph)
      PH_RST:  begin sb = 2'b10; res = 2'b10; end
      PH_F:    begin sb = 2'b10; res = 2'b10; irW = rdy; pcW = rdy; end
      PH_D:    begin sa = 2'b01; sb = 2'b01; end
      PH_MA:   begin sa = 2'b10; sb = 2'b01; end
      PH_MR:   adr = 1'b1;
      PH_MWB:  begin res = 2'b01; regW = 1'b1; end
      PH_MW:   begin adr = 1'b1; memW = 1'b1; end
      PH_ER:   begin sa = 2'b10; alu = functOp(ins); end
      PH_EI:   begin sa = 2'b10; sb = 2'b01; alu = functOp(ins); end
      PH_WB:   regW = 1'b1;
      PH_BEQ:  begin sa = 2'b10; alu = 3'b001; pcW = z; end
      PH_JAL:  begin sa = 2'b01; sb = 2'b10; pcW = 1'b1; end
      PH_HALT: ill = 1'b1;
      default: ;
    endcase
    return {pcW, adr, memW, irW, regW, res, sa, sb, alu, imm, ill};
  endfunction

  function automatic logic [16:0] actVec();
    logic ill;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    ill = bus.o_illegal;
`else
    ill = 1'b0;
`endif
    return {bus.o_pcWrite, bus.o_adrSrc, bus.o_memWrite, bus.o_irWrite, bus.o_regWrite,
            bus.o_resultSrc, bus.o_aluSrcA, bus.o_aluSrcB, bus.o_aluControl,
            bus.o_immediateSelect, ill};
  endfunction

  task automatic checkOutput(input string name, input logic [16:0] exp);
    logic [16:0] act;
    act = actVec();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  // One clock of stimulus; reset follows the phase so PH_RST asserts and anything else releases.
  task automatic applyStimulus(input phase_e ph, input logic [31:0] ins,
                               input logic rdy, input logic z);
    @(posedge clk);
    #1;
    rst            = (ph == PH_RST);
    bus.i_opcode   = ins[6:0];
    bus.i_funct3   = ins[14:12];
    bus.i_funct7b5 = ins[30];
    bus.i_memReady = rdy;
    bus.i_zero     = z;
    expQ.push_back(expVec(ph, ins, rdy, z));
    phQ.push_back(ph);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic runInstr(input logic [31:0] ins, input int fWait, input int mWait,
                          input logic bz);
    for (int i = 0; i <= fWait; i++) applyStimulus(PH_F, ins, i == fWait, rbit());
    applyStimulus(PH_D, ins, rbit(), rbit());
    case (ins[6:0])
      LW: begin
        applyStimulus(PH_MA, ins, rbit(), rbit());
        for (int i = 0; i <= mWait; i++) applyStimulus(PH_MR, ins, i == mWait, rbit());
        applyStimulus(PH_MWB, ins, rbit(), rbit());
      end
      SW: begin
        applyStimulus(PH_MA, ins, rbit(), rbit());
        for (int i = 0; i <= mWait; i++) applyStimulus(PH_MW, ins, i == mWait, rbit());
      end
      RT: begin
        applyStimulus(PH_ER, ins, rbit(), rbit());
        applyStimulus(PH_WB, ins, rbit(), rbit());
      end
      IT: begin
        applyStimulus(PH_EI, ins, rbit(), rbit());
        applyStimulus(PH_WB, ins, rbit(), rbit());
      end
      BQ: applyStimulus(PH_BEQ, ins, rbit(), bz);
      JL: begin
        applyStimulus(PH_JAL, ins, rbit(), rbit());
        applyStimulus(PH_WB, ins, rbit(), rbit());
      end
      default: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) applyStimulus(PH_HALT, ins, rbit(), rbit());
`endif
      end
    endcase
  endtask

  initial begin : monitor
    logic [16:0] e;
    phase_e      p;
    forever begin
      @(negedge clk);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        p = phQ.pop_front();
        checkOutput(p.name(), e);
      end
    end
  end

  initial begin : stimulus
    logic [31:0] ins;
    logic [6:0]  ops[7];
    int          nCls;
    ops = '{LW, SW, RT, IT, BQ, JL, 7'b0000000};
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    nCls = 6;
`else
    nCls = 7;
`endif
    rst = 1'b1;
    bus.i_opcode = '0; bus.i_funct3 = '0; bus.i_funct7b5 = 1'b0;
    bus.i_zero = 1'b0; bus.i_memReady = 1'b1;

    applyStimulus(PH_RST, 32'h0, 1'b1, 1'b0);
    applyStimulus(PH_RST, 32'h0, 1'b1, 1'b1);

    runInstr(32'hFFC4A303, 0, 0, 1'b0);
    runInstr(32'h0064A423, 0, 2, 1'b0);
    runInstr(32'h40B50533, 1, 0, 1'b0);
    runInstr(32'h40050513, 0, 0, 1'b0);
    runInstr(32'h00B50463, 0, 0, 1'b1);
    runInstr(32'h00B50463, 0, 0, 1'b0);
    runInstr(32'h008000EF, 0, 0, 1'b0);
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    runInstr(32'h00000000, 0, 0, 1'b0);
`endif

    // Abort a stalled store with an asynchronous reset in the middle of the cycle.
    ins = 32'h0064A423;
    applyStimulus(PH_F, ins, 1'b1, 1'b0);
    applyStimulus(PH_D, ins, 1'b1, 1'b0);
    applyStimulus(PH_MA, ins, 1'b1, 1'b0);
    applyStimulus(PH_MW, ins, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset in MEMWRITE", expVec(PH_RST, ins, 1'b0, 1'b0));
    applyStimulus(PH_RST, ins, 1'b0, 1'b0);
    runInstr(32'h00B50463, 0, 0, 1'b1);

    for (int n = 0; n < 60; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, nCls - 1)];
      runInstr(ins, $urandom_range(0, 2), $urandom_range(0, 2), rbit());
    end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    runInstr(32'h00000000, 0, 0, 1'b0);
    applyStimulus(PH_RST, 32'h0, 1'b1, 1'b0);
    runInstr(32'h008000EF, 0, 0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32I datapath (subset: lw, sw, R-type, I-type ALU, beq, jal).
- Sequences the shared ALU, the unified instruction/data memory port, the register file and the PC across multiple cycles per instruction.
- Drives the immediate select code consumed by the sign-extension unit.
- Sits beside the datapath and decodes fields of the instruction register.

Parameters:
- None. All encodings come from the shared package.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_opcode  input  7  instr[6:0] from instruction register
- i_funct3  input  3  instr[14:12]
- i_funct7b5  input  1  instr[30]
- i_zero  input  1  ALU zero flag
- i_memReady  input  1  memory completes the current access this cycle
- o_pcWrite  output  1  PC load enable
- o_adrSrc  output  1  memory address: 0 = PC, 1 = ALUOut
- o_memWrite  output  1  memory write strobe
- o_irWrite  output  1  instruction register (and oldPC) load
- o_regWrite  output  1  register file write
- o_resultSrc  output  2  00 = ALUOut, 01 = memory data, 10 = ALU result
- o_aluSrcA  output  2  00 = PC, 01 = oldPC, 10 = rs1
- o_aluSrcB  output  2  00 = rs2, 01 = immediate, 10 = constant 4
- o_aluControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- o_immediateSelect  output  2  00 = I, 01 = S, 10 = B, 11 = J

Behaviour:
- Moore FSM plus a combinational ALU decoder. Outputs are a function of state, except:
  - o_pcWrite in BEQ = i_zero.
  - Write enables gated by i_memReady where noted.
- Reset: state = FETCH. While i_rst is high, all write enables (pcWrite, memWrite, irWrite, regWrite) = 0. Mux selects take FETCH values.
- Reset mid-instruction aborts it. No partial writes follow.
- o_immediateSelect is combinational from i_opcode:
  - 0000011 / 0010011 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - other -> 00
- States and outputs (unlisted enables = 0, unlisted selects = 00):
  - FETCH: adrSrc=0, aluSrcA=00, aluSrcB=10, add, resultSrc=10. irWrite = pcWrite = i_memReady. Stay in FETCH until i_memReady, then go to DECODE.
  - DECODE: aluSrcA=01, aluSrcB=01, add (branch target into ALUOut). Next state by opcode:
    - lw / sw -> MEMADR
    - R (0110011) -> EXECUTER
    - I (0010011) -> EXECUTEI
    - beq -> BEQ
    - jal -> JAL
    - other -> FETCH
  - MEMADR: aluSrcA=10, aluSrcB=01, add. Next state: lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD: adrSrc=1. Hold until i_memReady, then go to MEMWB.
  - MEMWB: resultSrc=01, regWrite=1. Next state FETCH.
  - MEMWRITE: adrSrc=1, memWrite=1. Held every cycle until i_memReady, then go to FETCH.
  - EXECUTER: aluSrcA=10, aluSrcB=00, funct-decoded. Next state ALUWB.
  - EXECUTEI: aluSrcA=10, aluSrcB=01, funct-decoded. Next state ALUWB.
  - ALUWB: resultSrc=00, regWrite=1. Next state FETCH.
  - BEQ: aluSrcA=10, aluSrcB=00, sub, resultSrc=00, pcWrite=i_zero. Next state FETCH.
  - JAL: aluSrcA=01, aluSrcB=10, add, resultSrc=00, pcWrite=1. Next state ALUWB (writes PC+4).
- Funct decode:
  - funct3 000: sub if R-type and funct7b5 = 1, else add (addi never subtracts).
  - funct3 010 -> slt, 110 -> or, 111 -> and.
  - Other funct3 -> add.
- Latencies with i_memReady tied high (cycles per instruction):
  - lw = 5
  - sw = 4
  - R / I = 4
  - beq = 3
  - jal = 4
- Each memory wait cycle adds one cycle.

Optional Feature:
- Macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
- Defined:
  - Adds output o_illegal (1 bit).
  - An unrecognised opcode in DECODE goes to state HALT. HALT has all write enables = 0, o_illegal = 1, and never exits.
  - Only i_rst leaves HALT.
- Undefined:
  - No o_illegal port.
  - An unrecognised opcode in DECODE returns to FETCH (acts as nop).

Decomposition:
- Shared package holds:
  - state enum
  - opcode constants
  - aluControl, resultSrc, aluSrcA/B and immediateSelect enum typedefs
- Extension unit imports the immediateSelect typedef from the same package.
- One natural sub-module: alu_decoder (funct3, funct7b5, opcode bit 5, alu op class -> o_aluControl).

Test Plan:
- Reset asserted in MEMWRITE with i_memReady=0 -> memWrite drops to 0 immediately (asynchronous). Next state is FETCH and the cycle after reset shows irWrite=1.
- lw 0xFFC4A303, memReady=1 -> states F, D, MA, MR, MWB. immediateSelect=00, regWrite=1 only in cycle 5, resultSrc=01.
- sw 0x0064A423, memReady low for 2 cycles in MEMWRITE -> memWrite=1 for 3 cycles, adrSrc=1, immediateSelect=01, back to FETCH.
- R-type sub (opcode 0110011, funct3 000, f7b5=1) -> aluControl=001 in EXECUTER. addi with instr[30]=1 -> aluControl=000.
- beq with i_zero=1 -> pcWrite=1 in cycle 3. With i_zero=0 -> pcWrite=0. immediateSelect=10.
- jal -> JAL then ALUWB, pcWrite=1 in JAL, regWrite=1 in ALUWB. Opcode 0000000 -> FETCH (macro off) or sticky HALT with o_illegal=1 (macro on).
